// File: rtl/vga_vram_pkg.sv
// Shared types and constants for the VGA VRAM arbiter.
package vga_vram_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGntD,
    StGntC,
    StResp
  } state_e;

  localparam logic OWN_DISP = 1'b0;
  localparam logic OWN_CPU  = 1'b1;

endpackage

// File: rtl/vga_vram_watchdog.sv
// Transaction watchdog: counts cycles while enabled and flags the cycle in which
// the TIMEOUT-th enabled cycle is reached.
module vga_vram_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Count value equals the number of enabled cycles already elapsed.
  assign expire_o = en_i && (cnt_q == LAST);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expire_o) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter between the display scanout fetcher and a CPU requester,
// with a display-run starvation guard and a transaction watchdog.
module vga_vram_arbiter
  import vga_vram_pkg::*;
#(
  parameter int unsigned ADDR_W       = 24,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_DISP_RUN = 8,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              vblank_i,
  input  logic              disp_req_i,
  input  logic [ADDR_W-1:0] disp_addr_i,
  output logic              disp_ack_o,
  output logic [DATA_W-1:0] disp_data_o,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_ack_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o,
  output logic              err_src_o
);

  localparam int unsigned RUN_W = $clog2(MAX_DISP_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DISP_RUN);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              err_q, err_d;
  logic              err_src_q, err_src_d;
  logic              cpu_wins;
  logic              in_gnt;
  logic              wd_expire;

  assign in_gnt = (state_q == StGntD) || (state_q == StGntC);

  // CPU wins in vblank, when the display has used its run budget, or when alone.
  assign cpu_wins = cpu_req_i && (vblank_i || (run_q == RUN_MAX) || !disp_req_i);

  vga_vram_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clr_i    (!in_gnt),
    .en_i     (in_gnt),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    run_d       = run_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    disp_data_d = disp_data_q;
    cpu_rdata_d = cpu_rdata_q;
    err_d       = err_q;
    err_src_d   = err_src_q;

    unique case (state_q)
      StIdle: begin
        if (!cpu_req_i) begin
          run_d = '0;
        end
        if (cpu_wins) begin
          state_d = StGntC;
          owner_d = OWN_CPU;
          addr_d  = cpu_addr_i;
          we_d    = cpu_we_i;
          wdata_d = cpu_wdata_i;
          run_d   = '0;
        end else if (disp_req_i) begin
          state_d = StGntD;
          owner_d = OWN_DISP;
          addr_d  = disp_addr_i;
          we_d    = 1'b0;
          wdata_d = '0;
          if (cpu_req_i && (run_q != RUN_MAX)) begin
            run_d = run_q + RUN_W'(1);
          end
        end
      end
      StGntD, StGntC: begin
        // A completion in the expiry cycle takes precedence over the timeout.
        if (mem_ack_i) begin
          state_d = StResp;
          if (owner_q == OWN_CPU) begin
            cpu_rdata_d = mem_rdata_i;
          end else begin
            disp_data_d = mem_rdata_i;
          end
        end else if (wd_expire) begin
          state_d   = StResp;
          err_d     = 1'b1;
          err_src_d = owner_q;
          if (owner_q == OWN_CPU) begin
            cpu_rdata_d = '0;
          end else begin
            disp_data_d = '0;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      owner_q     <= OWN_DISP;
      run_q       <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      disp_data_q <= '0;
      cpu_rdata_q <= '0;
      err_q       <= 1'b0;
      err_src_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      run_q       <= run_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      disp_data_q <= disp_data_d;
      cpu_rdata_q <= cpu_rdata_d;
      err_q       <= err_d;
      err_src_q   <= err_src_d;
    end
  end

  assign mem_req_o   = in_gnt;
  assign mem_we_o    = in_gnt && we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign disp_ack_o  = (state_q == StResp) && (owner_q == OWN_DISP);
  assign cpu_ack_o   = (state_q == StResp) && (owner_q == OWN_CPU);
  assign disp_data_o = disp_data_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign err_o       = err_q;
  assign err_src_o   = err_src_q;

endmodule
